// File: rtl/audvid_pkg.sv
// Shared audio/video constants: default I2S word/FIFO sizes and receiver FSM encodings.
package audvid_pkg;

    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF   = 8;

    // Bit counter saturates at 31, so five bits are enough for any legal word.
    localparam int BIT_CNT_W = 5;

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

endpackage

// File: rtl/audio_fifo.sv
// First-word-fall-through frame FIFO; a push while full is accepted only if a pop frees a slot.
module audio_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S receiver: synchronizes the serial bus, deserializes left/right words and queues stereo frames.
module i2s_receiver
    import audvid_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          I2S_CLK,
    input  logic                          I2S_WS,
    input  logic                          I2S_DATA,
    output logic [2*SAMPLE_WIDTH-1:0]     OutputData,
    output logic                          DataValid,
    input  logic                          DataRead,
    output logic [$clog2(FIFO_DEPTH):0]   FifoCount,
    output logic                          Overflow,
    output logic                          FrameError,
    input  logic                          ClearFlags
);

    logic [1:0]              clk_sync;
    logic [1:0]              ws_sync;
    logic [1:0]              sd_sync;
    logic                    clk_prev;
    logic                    ws_prev;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] left_word;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [1:0]              state;
    logic [1:0]              state_next;

    logic                    bit_rise;
    logic                    ws;
    logic                    sd;
    logic                    word_end;
    logic                    len_ok;
    logic [SAMPLE_WIDTH-1:0] word;
    logic                    push;
    logic                    latch_left;
    logic                    frame_err;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    overflow_evt;

    assign bit_rise = clk_sync[1] & ~clk_prev;
    assign ws       = ws_sync[1];
    assign sd       = sd_sync[1];
    assign word_end = bit_rise & (ws != ws_prev);
    assign word     = {shift_reg[SAMPLE_WIDTH-2:0], sd};
    assign len_ok   = (bit_cnt == BIT_CNT_W'(SAMPLE_WIDTH - 1));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            clk_sync  <= '0;
            ws_sync   <= '0;
            sd_sync   <= '0;
            clk_prev  <= 1'b0;
            ws_prev   <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            clk_sync <= {clk_sync[0], I2S_CLK};
            ws_sync  <= {ws_sync[0], I2S_WS};
            sd_sync  <= {sd_sync[0], I2S_DATA};
            clk_prev <= clk_sync[1];
            if (bit_rise) begin
                ws_prev   <= ws;
                shift_reg <= word;
                if (word_end) begin
                    bit_cnt <= '0;
                end else if (bit_cnt != '1) begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                end
            end
        end
    end

    // Length errors are only meaningful once aligned; SYNC ignores the partial words it skips.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        latch_left = 1'b0;
        frame_err  = 1'b0;
        if (word_end) begin
            case (state)
                ST_LEFT: begin
                    if (!len_ok) begin
                        frame_err  = 1'b1;
                        state_next = ST_SYNC;
                    end else if (ws) begin
                        latch_left = 1'b1;
                        state_next = ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (!len_ok) begin
                        frame_err  = 1'b1;
                        state_next = ST_SYNC;
                    end else if (!ws) begin
                        push       = 1'b1;
                        state_next = ST_LEFT;
                    end
                end
                default: begin
                    if (!ws) begin
                        state_next = ST_LEFT;
                    end
                end
            endcase
        end
    end

    assign overflow_evt = push & fifo_full & ~(DataRead & ~fifo_empty);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_SYNC;
            left_word  <= '0;
            Overflow   <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            state <= state_next;
            if (latch_left) begin
                left_word <= word;
            end
            if (overflow_evt) begin
                Overflow <= 1'b1;
            end else if (ClearFlags) begin
                Overflow <= 1'b0;
            end
            if (frame_err) begin
                FrameError <= 1'b1;
            end else if (ClearFlags) begin
                FrameError <= 1'b0;
            end
        end
    end

    audio_fifo #(
        .WIDTH (2 * SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (Reset),
        .push    (push),
        .pop     (DataRead),
        .wr_data ({left_word, word}),
        .rd_data (OutputData),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (FifoCount)
    );

    assign DataValid = ~fifo_empty;

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: table-driven frames plus directed sync/overflow/error/reset sequences.
`timescale 1ns/1ps
module tb_i2s_receiver;

    localparam int SW    = 16;
    localparam int DEPTH = 8;

    logic        CLK;
    logic        Reset;
    logic        I2S_CLK;
    logic        I2S_WS;
    logic        I2S_DATA;
    logic [31:0] OutputData;
    logic        DataValid;
    logic        DataRead;
    logic [3:0]  FifoCount;
    logic        Overflow;
    logic        FrameError;
    logic        ClearFlags;

    i2s_receiver #(
        .SAMPLE_WIDTH (SW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .I2S_CLK    (I2S_CLK),
        .I2S_WS     (I2S_WS),
        .I2S_DATA   (I2S_DATA),
        .OutputData (OutputData),
        .DataValid  (DataValid),
        .DataRead   (DataRead),
        .FifoCount  (FifoCount),
        .Overflow   (Overflow),
        .FrameError (FrameError),
        .ClearFlags (ClearFlags)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        logic [31:0] expect_data;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] exp_q[$];
    int          n_cmp   = 0;
    int          n_err   = 0;
    int          half_ns = 381;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // mode 0: plain bit; 1: measure DataValid latency; 2: pop exactly when the push lands.
    task automatic drive_bit(input logic ws, input logic sd, input int mode);
        I2S_WS   = ws;
        I2S_DATA = sd;
        #(half_ns);
        @(negedge CLK);
        I2S_CLK = 1'b1;
        if (mode == 1) begin
            int lat;
            lat = 0;
            for (int k = 1; k <= 4; k++) begin
                @(posedge CLK);
                #1;
                if (DataValid && lat == 0) lat = k;
            end
            check("basic_valid_within_4clk", 32'(lat != 0), 32'd1);
        end else if (mode == 2) begin
            @(posedge CLK);
            @(posedge CLK);
            #1;
            check("full_head_at_coincident_pop", OutputData, exp_q.pop_front());
            DataRead = 1'b1;
            @(posedge CLK);
            #1;
            DataRead = 1'b0;
        end
        #(half_ns);
        I2S_CLK = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lbits, input int last_mode);
        for (int i = lbits - 1; i >= 1; i--) drive_bit(1'b0, l[i], 0);
        drive_bit(1'b1, l[0], 0);
        for (int i = 15; i >= 1; i--) drive_bit(1'b1, r[i], 0);
        drive_bit(1'b0, r[0], last_mode);
    endtask

    task automatic preamble();
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, 0);
        drive_bit(1'b0, 1'b0, 0);
    endtask

    task automatic settle();
        repeat (6) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic pop_check(input string name);
        int          waited;
        logic [31:0] want;
        waited = 0;
        while (!DataValid && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check({name, "_valid"}, 32'(DataValid), 32'd1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no expected frame queued", name);
        end else begin
            want = exp_q.pop_front();
            check(name, OutputData, want);
        end
        DataRead = 1'b1;
        @(negedge CLK);
        DataRead = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge CLK);
        Reset = 1'b1;
    endtask

    task automatic pulse_clear();
        @(negedge CLK);
        ClearFlags = 1'b1;
        @(negedge CLK);
        ClearFlags = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lw;
        logic [15:0] rw;

        Reset      = 1'b0;
        I2S_CLK    = 1'b0;
        I2S_WS     = 1'b0;
        I2S_DATA   = 1'b0;
        DataRead   = 1'b0;
        ClearFlags = 1'b0;

        vecs[0] = '{16'h0000, 16'hFFFF, 32'h0000FFFF};
        vecs[1] = '{16'hFFFF, 16'h0000, 32'hFFFF0000};
        vecs[2] = '{16'hA5A5, 16'h5A5A, 32'hA5A55A5A};
        vecs[3] = '{16'h8001, 16'h7FFE, 32'h80017FFE};

        repeat (3) @(negedge CLK);
        check("rst_count", 32'(FifoCount), 32'd0);
        check("rst_valid", 32'(DataValid), 32'd0);
        check("rst_data", OutputData, 32'd0);
        check("rst_overflow", 32'(Overflow), 32'd0);
        check("rst_frame_error", 32'(FrameError), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;

        // Basic frame at the nominal 1.312 MHz bit clock.
        preamble();
        check("basic_idle_valid", 32'(DataValid), 32'd0);
        exp_q.push_back(32'h1234ABCD);
        send_frame(16'h1234, 16'hABCD, 16, 1);
        settle();
        check("basic_count", 32'(FifoCount), 32'd1);
        pop_check("basic_data");
        check("basic_empty_after_pop", 32'(DataValid), 32'd0);

        half_ns = 40;

        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(vecs[i].expect_data);
            send_frame(vecs[i].left, vecs[i].right, 16, 0);
        end
        settle();
        check("table_count", 32'(FifoCount), 32'd4);
        for (int i = 0; i < 4; i++) pop_check($sformatf("table_%0d", i));

        // Stream starts mid-right-word after a reset.
        do_reset();
        for (int i = 0; i < 7; i++) drive_bit(1'b1, 1'($urandom_range(0, 1)), 0);
        drive_bit(1'b0, 1'b1, 0);
        settle();
        check("sync_partial_dropped", 32'(FifoCount), 32'd0);
        exp_q.push_back(32'h00018000);
        send_frame(16'h0001, 16'h8000, 16, 0);
        settle();
        check("sync_count", 32'(FifoCount), 32'd1);
        pop_check("sync_data");

        for (int i = 0; i < 9; i++) begin
            lw = 16'($urandom);
            rw = 16'($urandom);
            if (i < 8) exp_q.push_back({lw, rw});
            send_frame(lw, rw, 16, 0);
        end
        settle();
        check("ovf_count", 32'(FifoCount), 32'd8);
        check("ovf_flag", 32'(Overflow), 32'd1);
        check("ovf_no_frame_error", 32'(FrameError), 32'd0);
        for (int i = 0; i < 8; i++) pop_check($sformatf("ovf_pop_%0d", i));
        check("ovf_drained", 32'(DataValid), 32'd0);
        pulse_clear();
        check("ovf_cleared", 32'(Overflow), 32'd0);

        // 15-bit left word, then a correct frame after resync.
        send_frame(16'h7FFF, 16'h1111, 15, 0);
        settle();
        check("ferr_flag", 32'(FrameError), 32'd1);
        check("ferr_no_push", 32'(FifoCount), 32'd0);
        exp_q.push_back(32'hCAFE0F0F);
        send_frame(16'hCAFE, 16'h0F0F, 16, 0);
        settle();
        check("ferr_resync_count", 32'(FifoCount), 32'd1);
        check("ferr_sticky", 32'(FrameError), 32'd1);
        pop_check("ferr_resync_data");
        pulse_clear();
        check("ferr_cleared", 32'(FrameError), 32'd0);

        for (int i = 0; i < 8; i++) begin
            lw = 16'($urandom);
            rw = 16'($urandom);
            exp_q.push_back({lw, rw});
            send_frame(lw, rw, 16, 0);
        end
        settle();
        check("full_count_before", 32'(FifoCount), 32'd8);
        lw = 16'($urandom);
        rw = 16'($urandom);
        exp_q.push_back({lw, rw});
        send_frame(lw, rw, 16, 2);
        settle();
        check("full_count_after", 32'(FifoCount), 32'd8);
        check("full_no_overflow", 32'(Overflow), 32'd0);
        for (int i = 0; i < 8; i++) pop_check($sformatf("full_pop_%0d", i));
        check("full_drained", 32'(DataValid), 32'd0);

        // Reset asserted during bit 7 of a right word with three frames stored.
        for (int i = 0; i < 3; i++) begin
            lw = 16'($urandom);
            rw = 16'($urandom);
            exp_q.push_back({lw, rw});
            send_frame(lw, rw, 16, 0);
        end
        settle();
        check("rstmid_count_before", 32'(FifoCount), 32'd3);
        lw = 16'($urandom);
        rw = 16'($urandom);
        for (int i = 15; i >= 1; i--) drive_bit(1'b0, lw[i], 0);
        drive_bit(1'b1, lw[0], 0);
        for (int i = 15; i >= 8; i--) drive_bit(1'b1, rw[i], 0);
        I2S_WS   = 1'b1;
        I2S_DATA = rw[7];
        #(half_ns);
        @(negedge CLK);
        I2S_CLK = 1'b1;
        #(half_ns / 2);
        Reset = 1'b0;
        exp_q.delete();
        #1;
        check("rstmid_count", 32'(FifoCount), 32'd0);
        check("rstmid_valid", 32'(DataValid), 32'd0);
        check("rstmid_data", OutputData, 32'd0);
        #(half_ns);
        I2S_CLK = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        for (int i = 6; i >= 1; i--) drive_bit(1'b1, rw[i], 0);
        drive_bit(1'b0, rw[0], 0);
        settle();
        check("rstmid_tail_dropped", 32'(FifoCount), 32'd0);
        exp_q.push_back(32'h5EED1E55);
        send_frame(16'h5EED, 16'h1E55, 16, 0);
        settle();
        check("rstmid_resync_count", 32'(FifoCount), 32'd1);
        pop_check("rstmid_resync_data");
        check("rstmid_no_frame_error", 32'(FrameError), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
